// File: rtl/riscboy_ppu_sprite_engine_pkg.sv
// Shared types and helpers for the per-sprite scanline engine.
package riscboy_ppu_sprite_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_QUERY = 2'd1,
    S_PRE   = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  // Pixel mode to log2(bits per pixel); modes above 16bpp clamp to 16bpp.
  function automatic logic [2:0] mode_log_pixsize(input logic [2:0] pixmode);
    mode_log_pixsize = (pixmode > 3'd4) ? 3'd4 : pixmode;
  endfunction

endpackage

// File: rtl/riscboy_ppu_sprite_shiftbuf.sv
// Holding buffer plus pixel shift register for one sprite line.
module riscboy_ppu_sprite_shiftbuf #(
  parameter int W_DATA     = 32,
  parameter int W_SHIFTCTR = $clog2(W_DATA)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  load_first,
  input  logic [W_DATA-1:0]     load_data,
  input  logic [W_SHIFTCTR-1:0] seek,
  input  logic                  consume,
  input  logic [2:0]            log,
  output logic                  empty,
  output logic [W_SHIFTCTR:0]   bits,
  output logic [15:0]           data
);

  localparam int W_BITS = W_SHIFTCTR + 1;

  logic [W_DATA-1:0] hb_data;
  logic              hb_valid;
  logic              hb_first;
  logic [W_DATA-1:0] sr;
  logic [W_BITS-1:0] bits_r;
  logic [W_BITS-1:0] pix_w;
  logic [W_BITS-1:0] off;
  logic [15:0]       mask;
  logic              transfer;

  assign pix_w    = W_BITS'(1) << log;
  assign off      = hb_first ? {1'b0, seek} : '0;
  assign transfer = hb_valid && (bits_r == '0);
  assign mask     = 16'((17'd1 << pix_w) - 17'd1);

  assign empty = !hb_valid;
  assign bits  = bits_r;
  assign data  = sr[15:0] & mask;

  // Move HB into SR once SR drains; otherwise shift out one pixel per consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_data  <= '0;
      hb_valid <= 1'b0;
      hb_first <= 1'b0;
      sr       <= '0;
      bits_r   <= '0;
    end else if (clear) begin
      hb_data  <= '0;
      hb_valid <= 1'b0;
      hb_first <= 1'b0;
      sr       <= '0;
      bits_r   <= '0;
    end else begin
      if (transfer) begin
        sr       <= hb_data >> off;
        bits_r   <= W_BITS'(W_DATA) - off;
        hb_valid <= 1'b0;
      end else if (consume && bits_r != '0) begin
        sr     <= sr >> pix_w;
        bits_r <= (bits_r > pix_w) ? bits_r - pix_w : '0;
      end
      if (load) begin
        hb_data  <= load_data;
        hb_first <= load_first;
        hb_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/riscboy_ppu_sprite_engine.sv
// Per-sprite scanline engine: AGU query, tile-row fetch, beam-synchronous pixel output.
module riscboy_ppu_sprite_engine
  import riscboy_ppu_sprite_engine_pkg::*;
#(
  parameter int W_DATA     = 32,
  parameter int W_COORD    = 10,
  parameter int W_SHIFTCTR = $clog2(W_DATA)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scanline_start,
  input  logic                  beam_advance,
  input  logic [2:0]            cfg_pixmode,
  output logic                  agu_req,
  input  logic                  agu_ack,
  input  logic                  agu_active,
  input  logic [W_COORD-1:0]    agu_x_precount,
  input  logic [4:0]            agu_x_postcount,
  input  logic [W_SHIFTCTR-1:0] agu_shift_seek_target,
  output logic                  bus_vld,
  input  logic                  bus_rdy,
  output logic [4:0]            bus_postcount,
  input  logic [W_DATA-1:0]     bus_data,
  output logic                  pix_vld,
  output logic [15:0]           pix_data,
  output logic                  pix_underrun
);

  localparam int W_BITS = W_SHIFTCTR + 1;

  // Bus handshake: bus_vld rises only when HB is free and pixels remain to be
  // fetched, then stays high (with bus_postcount frozen) until bus_rdy; a word
  // transfers on every edge where both are high. A request outstanding across
  // an abort still completes, and its data is thrown away via flush.

  state_t                state, state_nxt;
  logic [W_COORD-1:0]    precount;
  logic [4:0]            postcount;
  logic [W_SHIFTCTR-1:0] seek;
  logic [4:0]            fetch_rem;
  logic                  first_fetch;
  logic                  bus_vld_r;
  logic [4:0]            bus_pc_r;
  logic                  flush;

  logic [2:0]            log_pix;
  logic                  sb_empty;
  logic [W_BITS-1:0]     sb_bits;
  logic [15:0]           sb_data;
  logic [W_BITS-1:0]     off_f;
  logic [W_BITS-1:0]     fetch_pix;
  logic                  active_state, handshake, run_adv, pix_avail;
  logic                  consume, clear, load, issue, ack_take;

  assign log_pix      = mode_log_pixsize(cfg_pixmode);
  assign active_state = (state == S_PRE) || (state == S_RUN);
  assign handshake    = bus_vld_r && bus_rdy;
  assign pix_avail    = (sb_bits != '0);
  assign run_adv      = (state == S_RUN) && beam_advance && !scanline_start;
  assign consume      = run_adv && pix_avail;
  assign clear        = scanline_start || (run_adv && (!pix_avail || postcount <= 5'd1));
  assign load         = handshake && !flush && active_state && !clear;
  assign issue        = active_state && (fetch_rem != '0) && sb_empty && !bus_vld_r
                        && !scanline_start;
  assign ack_take     = (state == S_QUERY) && agu_ack && !scanline_start;
  assign off_f        = first_fetch ? {1'b0, seek} : '0;
  assign fetch_pix    = (W_BITS'(W_DATA) - off_f) >> log_pix;

  assign bus_vld       = bus_vld_r;
  assign bus_postcount = bus_pc_r;
  assign pix_vld       = (state == S_RUN) && pix_avail;
  assign pix_data      = sb_data;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-state outputs; scanline_start overrides everything.
  always_comb begin
    state_nxt    = state;
    agu_req      = (state == S_QUERY);
    pix_underrun = run_adv && !pix_avail;
    if (scanline_start) begin
      state_nxt = S_QUERY;
    end else begin
      case (state)
        S_QUERY: if (agu_ack) begin
          if (!agu_active || agu_x_postcount == '0) state_nxt = S_IDLE;
          else if (agu_x_precount != '0)            state_nxt = S_PRE;
          else                                       state_nxt = S_RUN;
        end
        S_PRE:   if (beam_advance && precount <= W_COORD'(1)) state_nxt = S_RUN;
        S_RUN:   if (beam_advance && (!pix_avail || postcount <= 5'd1)) state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // Line counters: latched on ack, stepped by beam advances and fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      precount    <= '0;
      postcount   <= '0;
      seek        <= '0;
      fetch_rem   <= '0;
      first_fetch <= 1'b0;
    end else if (ack_take) begin
      precount    <= agu_x_precount;
      postcount   <= agu_x_postcount;
      seek        <= agu_shift_seek_target;
      fetch_rem   <= agu_x_postcount;
      first_fetch <= 1'b1;
    end else begin
      if (state == S_PRE && beam_advance && !scanline_start && precount != '0)
        precount <= precount - W_COORD'(1);
      if (consume)
        postcount <= postcount - 5'd1;
      if (load) begin
        fetch_rem   <= (32'(fetch_pix) < 32'(fetch_rem)) ? fetch_rem - 5'(fetch_pix) : '0;
        first_fetch <= 1'b0;
      end
    end
  end

  // Fetch request: hold until accepted; mark stale if the line is aborted meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_vld_r <= 1'b0;
      bus_pc_r  <= '0;
      flush     <= 1'b0;
    end else begin
      if (bus_vld_r) begin
        if (bus_rdy) bus_vld_r <= 1'b0;
      end else if (issue) begin
        bus_vld_r <= 1'b1;
        bus_pc_r  <= fetch_rem;
      end
      if (handshake)                         flush <= 1'b0;
      else if (bus_vld_r && scanline_start)  flush <= 1'b1;
    end
  end

  riscboy_ppu_sprite_shiftbuf #(
    .W_DATA     (W_DATA),
    .W_SHIFTCTR (W_SHIFTCTR)
  ) u_shiftbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .load       (load),
    .load_first (first_fetch),
    .load_data  (bus_data),
    .seek       (seek),
    .consume    (consume),
    .log        (log_pix),
    .empty      (sb_empty),
    .bits       (sb_bits),
    .data       (sb_data)
  );

endmodule
